// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM states, sprite region defaults and
// download index map.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck
    } ld_state_e;

    localparam logic [24:0] SP_BASE_DEF     = 25'h10000;
    localparam logic [24:0] SP_END_DEF      = 25'h1C000;
    localparam logic [7:0]  ACK_TIMEOUT_DEF = 8'd255;

    localparam logic [7:0]  ROM_INDEX = 8'd0;
    localparam logic [7:0]  DIP_INDEX = 8'd254;
    localparam int unsigned DIP_BYTES = 8;

    // DIP bytes live in the first DIP_BYTES addresses of the index-254 stream.
    function automatic logic is_dip_addr(input logic [24:0] addr);
        return addr[24:3] == 22'd0;
    endfunction

endpackage

// File: rtl/sp_addr_remap.sv
// Sprite ROM address remap: classifies a download address as sprite data and scrambles
// its offset into the port-2 word address and byte lane.
module sp_addr_remap
    import rom_loader_pkg::*;
#(
    parameter logic [24:0] SP_BASE = SP_BASE_DEF,
    parameter logic [24:0] SP_END  = SP_END_DEF
) (
    input  logic [24:0] addr,
    output logic        is_sprite,
    output logic [22:0] sp_a,
    output logic [1:0]  sp_ds
);

    logic [24:0] s;
    logic        unused_s_msb;

    assign s            = addr - SP_BASE;
    assign unused_s_msb = s[24];
    assign is_sprite    = (addr >= SP_BASE) && (addr < SP_END);
    // Offset bit 15 becomes the word LSB and bit 14 picks the byte lane.
    assign sp_a         = {s[23:16], s[13:0], s[15]};
    assign sp_ds        = {s[14], ~s[14]};

endmodule

// File: rtl/rom_loader.sv
// ROM download loader: commits HPS ioctl bytes to SDRAM ports 1/2 over a toggle
// handshake, captures DIP switch bytes and reports load completion/errors.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [24:0] SP_BASE     = SP_BASE_DEF,
    parameter logic [24:0] SP_END      = SP_END_DEF,
    parameter logic [7:0]  ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic [7:0]             ioctl_index,
    output logic                   ioctl_wait,
    output logic                   port1_req,
    input  logic                   port1_ack,
    output logic [22:0]            port1_a,
    output logic [1:0]             port1_ds,
    output logic [15:0]            port1_d,
    output logic                   port1_we,
    output logic                   port2_req,
    input  logic                   port2_ack,
    output logic [22:0]            port2_a,
    output logic [1:0]             port2_ds,
    output logic [15:0]            port2_d,
    output logic                   port2_we,
    output logic [8*DIP_BYTES-1:0] dip_sw,
    output logic                   rom_loaded,
    output logic                   load_err
);

    ld_state_e              state_q, state_d;
    logic [7:0]             timeout_q, timeout_d;
    logic                   req1_q, req1_d;
    logic                   req2_q, req2_d;
    logic [24:0]            addr_q;
    logic [7:0]             data_q;
    logic                   wr_q, dl_q;
    logic [8*DIP_BYTES-1:0] dip_q;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    logic                   pend_q, pend_d;

    logic wr_rise, dl_rise, dl_fall, idx_rom, idle;
    logic accept, overrun, dip_wr, acks_done, to_expire;
    logic is_sprite;

    assign wr_rise = ioctl_wr & ~wr_q;
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign idx_rom = ioctl_index == ROM_INDEX;
    assign idle    = state_q == StIdle;
    assign accept  = wr_rise & ioctl_download & idx_rom & idle;
    // Any strobe that arrives while a byte is still in flight is lost.
    assign overrun = wr_rise & ~idle;
    assign dip_wr  = wr_rise & ioctl_download & idle & (ioctl_index == DIP_INDEX) &
                     is_dip_addr(ioctl_addr);

    sp_addr_remap #(
        .SP_BASE(SP_BASE),
        .SP_END (SP_END)
    ) u_sp_addr_remap (
        .addr     (addr_q),
        .is_sprite(is_sprite),
        .sp_a     (port2_a),
        .sp_ds    (port2_ds)
    );

    assign acks_done = (port1_ack == req1_q) & (~is_sprite | (port2_ack == req2_q));

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        req1_d    = req1_q;
        req2_d    = req2_q;
        to_expire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                req1_d    = ~req1_q;
                req2_d    = is_sprite ? ~req2_q : req2_q;
                timeout_d = '0;
                state_d   = StWaitAck;
            end
            StWaitAck: begin
                if (acks_done) begin
                    state_d = StIdle;
                end else begin
                    timeout_d = timeout_q + 8'd1;
                    if (timeout_d == ACK_TIMEOUT) begin
                        to_expire = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        loaded_d = loaded_q;
        err_d    = err_q;
        pend_d   = pend_q;
        if (dl_rise && idx_rom) begin
            loaded_d = 1'b0;
            err_d    = 1'b0;
            pend_d   = 1'b0;
        end
        if (dl_fall && idx_rom) pend_d = 1'b1;
        // Completion waits until any in-flight byte has been acknowledged.
        if (pend_d && idle) begin
            loaded_d = 1'b1;
            pend_d   = 1'b0;
        end
        if (overrun || to_expire) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            timeout_q <= '0;
            req1_q    <= 1'b0;
            req2_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            dl_q      <= 1'b0;
            dip_q     <= '0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            req1_q    <= req1_d;
            req2_q    <= req2_d;
            wr_q      <= ioctl_wr;
            dl_q      <= ioctl_download;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            if (accept) begin
                addr_q <= ioctl_addr;
                data_q <= ioctl_dout;
            end
            if (dip_wr) dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    assign ioctl_wait = accept | ~idle;
    assign port1_req  = req1_q;
    assign port2_req  = req2_q;
    assign port1_a    = addr_q[23:1];
    assign port1_ds   = {addr_q[0], ~addr_q[0]};
    assign port1_d    = {data_q, data_q};
    assign port2_d    = {data_q, data_q};
    assign port1_we   = ioctl_download;
    assign port2_we   = ioctl_download;
    assign dip_sw     = dip_q;
    assign rom_loaded = loaded_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: CPU/sprite byte commits, region bounds,
// DIP capture, ack timeout, overrun, completion flag and mid-handshake reset.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        port1_req, port1_ack = 1'b0;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;
    logic        port2_req, port2_ack = 1'b0;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port2_we;
    logic [63:0] dip_sw;
    logic        rom_loaded, load_err;

    int   errors = 0;
    int   checks = 0;
    logic exp_r1 = 1'b0;
    logic exp_r2 = 1'b0;

    always #5 clk = ~clk;

    rom_loader dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .port1_req     (port1_req),
        .port1_ack     (port1_ack),
        .port1_a       (port1_a),
        .port1_ds      (port1_ds),
        .port1_d       (port1_d),
        .port1_we      (port1_we),
        .port2_req     (port2_req),
        .port2_ack     (port2_ack),
        .port2_a       (port2_a),
        .port2_ds      (port2_ds),
        .port2_d       (port2_d),
        .port2_we      (port2_we),
        .dip_sw        (dip_sw),
        .rom_loaded    (rom_loaded),
        .load_err      (load_err)
    );

    // Strobes one index-0 byte and plays the SDRAM side; returns cycles with ioctl_wait high.
    task automatic run_byte(input logic [24:0] addr, input logic [7:0] data, input logic sprite,
                            input int ack1_at, input int ack2_at, output int wcnt);
        exp_r1 = ~exp_r1;
        if (sprite) exp_r2 = ~exp_r2;
        wcnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ioctl_addr = addr;
                ioctl_dout = data;
                ioctl_wr   = 1'b1;
            end
            if (c == 1) ioctl_wr = 1'b0;
            if (c == ack1_at) port1_ack = exp_r1;
            if (c == ack2_at) port2_ack = exp_r2;
            #1;
            if (ioctl_wait) wcnt++;
            else break;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
        checks++; if ({port1_req, port2_req} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b want 00", {port1_req, port2_req}); end
        checks++; if (port1_a !== 23'h0 || port1_d !== 16'h0) begin errors++; $display("FAIL reset_hold: got a=%h d=%h want 0", port1_a, port1_d); end
        checks++; if (dip_sw !== 64'h0) begin errors++; $display("FAIL reset_dip: got %h want 0", dip_sw); end
        checks++; if ({rom_loaded, load_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {rom_loaded, load_err}); end
    endtask

    task automatic test_dip;
        logic [24:0] dip_addr [3] = '{25'd1, 25'd8, 25'd7};
        logic [7:0]  dip_data [3] = '{8'h81, 8'h55, 8'hA5};
        ioctl_index = 8'd254;
        @(negedge clk);
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ioctl_addr = dip_addr[i];
            ioctl_dout = dip_data[i];
            ioctl_wr   = 1'b1;
            #1;
            checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL dip_wait[%0d]: got %b want 0", i, ioctl_wait); end
            @(negedge clk);
            ioctl_wr = 1'b0;
            if (i == 0) begin
                checks++; if (dip_sw !== 64'h0000_0000_0000_8100) begin errors++; $display("FAIL dip_byte1: got %h want 8100", dip_sw); end
            end
            if (i == 1) begin
                checks++; if (dip_sw !== 64'h0000_0000_0000_8100) begin errors++; $display("FAIL dip_addr8_ignored: got %h want 8100", dip_sw); end
            end
        end
        @(negedge clk);
        checks++; if (dip_sw !== 64'hA500_0000_0000_8100) begin errors++; $display("FAIL dip_byte7: got %h want a500000000008100", dip_sw); end
        checks++; if ({port1_req, port2_req} !== {exp_r1, exp_r2}) begin errors++; $display("FAIL dip_no_req: got %b want %b", {port1_req, port2_req}, {exp_r1, exp_r2}); end
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("FAIL dip_end_not_loaded: got %b want 0", rom_loaded); end
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk);
        checks++; if ({port1_we, port2_we} !== 2'b11) begin errors++; $display("FAIL we_follow_dl: got %b want 11", {port1_we, port2_we}); end
    endtask

    task automatic test_cpu_byte;
        int w;
        run_byte(25'h00003, 8'h5A, 1'b0, 5, -1, w);
        checks++; if (w !== 6) begin errors++; $display("FAIL cpu_wait_cycles: got %0d want 6", w); end
        checks++; if (port1_a !== 23'h000001) begin errors++; $display("FAIL cpu_a: got %h want 000001", port1_a); end
        checks++; if (port1_ds !== 2'b10) begin errors++; $display("FAIL cpu_ds: got %b want 10", port1_ds); end
        checks++; if (port1_d !== 16'h5A5A) begin errors++; $display("FAIL cpu_d: got %h want 5a5a", port1_d); end
        checks++; if ({port1_req, port2_req} !== {exp_r1, exp_r2}) begin errors++; $display("FAIL cpu_req: got %b want %b", {port1_req, port2_req}, {exp_r1, exp_r2}); end
    endtask

    task automatic test_sprite_byte;
        int w;
        run_byte(25'h14001, 8'hC3, 1'b1, 3, 6, w);
        checks++; if (w !== 7) begin errors++; $display("FAIL sp_wait_both_acks: got %0d want 7", w); end
        checks++; if ({port1_req, port2_req} !== {exp_r1, exp_r2}) begin errors++; $display("FAIL sp_req: got %b want %b", {port1_req, port2_req}, {exp_r1, exp_r2}); end
        checks++; if (port2_a !== 23'h000002) begin errors++; $display("FAIL sp_a: got %h want 000002", port2_a); end
        // Offset 0x04001 has bit 14 set, selecting the upper lane.
        checks++; if (port2_ds !== 2'b10) begin errors++; $display("FAIL sp_ds: got %b want 10", port2_ds); end
        checks++; if (port2_d !== 16'hC3C3) begin errors++; $display("FAIL sp_d: got %h want c3c3", port2_d); end
        checks++; if (port1_a !== 23'h00A000) begin errors++; $display("FAIL sp_p1_a: got %h want 00a000", port1_a); end
    endtask

    task automatic test_region_bounds;
        int w;
        run_byte(25'h0FFFF, 8'h01, 1'b0, 2, -1, w);
        checks++; if (port2_req !== exp_r2 || port1_a !== 23'h007FFF) begin errors++; $display("FAIL below_base: got r2=%b a=%h want r2=%b a=007fff", port2_req, port1_a, exp_r2); end
        run_byte(25'h1C000, 8'h02, 1'b0, 2, -1, w);
        checks++; if (port2_req !== exp_r2 || port1_ds !== 2'b01) begin errors++; $display("FAIL at_end: got r2=%b ds=%b want r2=%b ds=01", port2_req, port1_ds, exp_r2); end
        run_byte(25'h10000, 8'h03, 1'b1, 2, 2, w);
        checks++; if (port2_req !== exp_r2 || port2_a !== 23'h0 || port2_ds !== 2'b01) begin errors++; $display("FAIL at_base: got r2=%b a=%h ds=%b want r2=%b a=0 ds=01", port2_req, port2_a, port2_ds, exp_r2); end
        run_byte(25'h1BFFF, 8'h04, 1'b1, 2, 2, w);
        checks++; if (port2_a !== 23'h007FFF || port2_ds !== 2'b01) begin errors++; $display("FAIL last_sprite: got a=%h ds=%b want a=007fff ds=01", port2_a, port2_ds); end
        checks++; if (w !== 3) begin errors++; $display("FAIL quick_ack_wait: got %0d want 3", w); end
    endtask

    task automatic test_timeout;
        int w;
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_before_timeout: got %b want 0", load_err); end
        run_byte(25'h00010, 8'h99, 1'b0, -1, -1, w);
        checks++; if (w !== 257) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 257", w); end
        checks++; if (load_err !== 1'b1 || ioctl_wait !== 1'b0) begin errors++; $display("FAIL timeout_err: got err=%b wait=%b want err=1 wait=0", load_err, ioctl_wait); end
        port1_ack = exp_r1;
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
        checks++; if (rom_loaded !== 1'b1 || load_err !== 1'b1) begin errors++; $display("FAIL loaded_after_fall: got loaded=%b err=%b want 1 1", rom_loaded, load_err); end
        ioctl_download = 1'b1;
        @(negedge clk);
        checks++; if ({rom_loaded, load_err} !== 2'b00) begin errors++; $display("FAIL restart_clears: got %b want 00", {rom_loaded, load_err}); end
    endtask

    task automatic test_overrun;
        exp_r1 = ~exp_r1;
        @(negedge clk);
        ioctl_addr = 25'h00020; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (2) @(negedge clk);
        ioctl_addr = 25'h00040; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        #1;
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b want 1", load_err); end
        checks++; if (port1_a !== 23'h10 || port1_d !== 16'h1111) begin errors++; $display("FAIL overrun_dropped: got a=%h d=%h want 10 1111", port1_a, port1_d); end
        port1_ack = exp_r1;
        @(negedge clk);
        #1;
        checks++; if (ioctl_wait !== 1'b0 || port1_req !== exp_r1) begin errors++; $display("FAIL overrun_done: got wait=%b r1=%b want 0 %b", ioctl_wait, port1_req, exp_r1); end
    endtask

    task automatic test_loaded_during_wait;
        exp_r1 = ~exp_r1;
        @(negedge clk);
        ioctl_addr = 25'h00030; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rom_loaded !== 1'b0 || port1_we !== 1'b0) begin errors++; $display("FAIL fall_in_wait: got loaded=%b we=%b want 0 0", rom_loaded, port1_we); end
        port1_ack = exp_r1;
        repeat (2) @(negedge clk);
        checks++; if (rom_loaded !== 1'b1 || port1_a !== 23'h18) begin errors++; $display("FAIL loaded_after_ack: got loaded=%b a=%h want 1 18", rom_loaded, port1_a); end
        ioctl_download = 1'b1;
        @(negedge clk);
        checks++; if ({rom_loaded, load_err} !== 2'b00) begin errors++; $display("FAIL restart2_clears: got %b want 00", {rom_loaded, load_err}); end
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        ioctl_addr = 25'h14001; ioctl_dout = 8'h3C; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
        checks++; if (port2_req !== ~exp_r2) begin errors++; $display("FAIL pre_reset_req2: got %b want %b", port2_req, ~exp_r2); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({port1_req, port2_req, ioctl_wait} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl: got %b want 000", {port1_req, port2_req, ioctl_wait}); end
        checks++; if (port1_a !== 23'h0 || port2_d !== 16'h0 || dip_sw !== 64'h0) begin errors++; $display("FAIL rst_mid_regs: got a=%h d=%h dip=%h want 0", port1_a, port2_d, dip_sw); end
        reset = 1'b0;
        port1_ack = 1'b0; port2_ack = 1'b0;
        exp_r1 = 1'b0; exp_r2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({port1_req, port2_req, ioctl_wait} !== 3'b000) begin errors++; $display("FAIL rst_mid_quiet: got %b want 000", {port1_req, port2_req, ioctl_wait}); end
    endtask

    task automatic test_final_load;
        int w;
        run_byte(25'h00100, 8'h77, 1'b0, 2, -1, w);
        checks++; if (w !== 3 || port1_a !== 23'h80 || port1_req !== exp_r1) begin errors++; $display("FAIL final_byte: got w=%0d a=%h r1=%b want 3 80 %b", w, port1_a, port1_req, exp_r1); end
        ioctl_download = 1'b0;
        @(negedge clk);
        checks++; if (rom_loaded !== 1'b1) begin errors++; $display("FAIL final_loaded: got %b want 1", rom_loaded); end
    endtask

    initial begin
        test_reset;
        test_dip;
        test_cpu_byte;
        test_sprite_byte;
        test_region_bounds;
        test_timeout;
        test_overrun;
        test_loaded_during_wait;
        test_reset_mid_wait;
        test_final_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
